// File: rtl/tdc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tdc_fifo_reader
// Brief    : Pops TDC words from the result FIFO and serialises them into
//            bytes over a new_tx_data / tx_busy handshake. Optional build
//            macro SYNC_HEADER_EN prefixes each frame with sync byte 8'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_fifo_reader #(
    parameter int DATA_BYTES   = 3,
    parameter int READ_LATENCY = 1,
    parameter bit MSB_FIRST    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    input  logic [8*DATA_BYTES-1:0] fifo_dout,
    output logic                    fifo_rd_en,
    input  logic                    tx_busy,
    output logic [7:0]              tx_data,
    output logic                    new_tx_data,
    output logic                    f_FIFO_reading_done
);

    localparam int c_WORD_W = 8 * DATA_BYTES;
    localparam int c_CNT_W  = $clog2(DATA_BYTES + 1);
    localparam int c_LAT_W  = $clog2(READ_LATENCY + 1);
`ifdef SYNC_HEADER_EN
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
`ifdef SYNC_HEADER_EN
        S_HEADER    = 3'd2,
`endif
        S_SEND      = 3'd3,
        S_HOLD      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_WORD_W-1:0]   r_shift;
    logic [c_CNT_W-1:0]    r_byte_cnt;
    logic [c_LAT_W-1:0]    r_lat_cnt;
    logic                  r_rd_en;
    logic [7:0]            r_tx_data;
    logic                  r_new_tx;
    logic                  r_done;

    state_t                w_state_nxt;
    logic                  w_rd_en_nxt;
    logic [7:0]            w_tx_data_nxt;
    logic                  w_new_tx_nxt;
    logic                  w_done_nxt;
    logic                  w_capture;
    logic                  w_advance;
    logic [7:0]            w_cur_byte;
    logic [c_WORD_W-1:0]   w_shift_nxt;

    // The byte on deck always sits at the outgoing end of the shift register.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_cur_byte  = r_shift[c_WORD_W-1 -: 8];
            assign w_shift_nxt = r_shift << 8;
        end else begin : g_lsb_first
            assign w_cur_byte  = r_shift[7:0];
            assign w_shift_nxt = r_shift >> 8;
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_en_nxt   = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_new_tx_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                // Counter starts at 0 in the cycle fifo_rd_en is high.
                if (r_lat_cnt == c_LAT_W'(READ_LATENCY)) begin
                    w_capture   = 1'b1;
`ifdef SYNC_HEADER_EN
                    w_state_nxt = S_HEADER;
`else
                    w_state_nxt = S_SEND;
`endif
                end
            end
`ifdef SYNC_HEADER_EN
            S_HEADER: begin
                if (!tx_busy) begin
                    w_tx_data_nxt = c_SYNC_BYTE;
                    w_new_tx_nxt  = 1'b1;
                    w_state_nxt   = S_HOLD;
                end
            end
`endif
            S_SEND: begin
                if (!tx_busy) begin
                    w_tx_data_nxt = w_cur_byte;
                    w_new_tx_nxt  = 1'b1;
                    w_advance     = 1'b1;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                // tx_busy is not looked at here: the transmitter needs a cycle to raise it.
                if (r_byte_cnt < c_CNT_W'(DATA_BYTES)) begin
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_lat_cnt  <= '0;
            r_rd_en    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_new_tx   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_new_tx  <= w_new_tx_nxt;
            r_done    <= w_done_nxt;
            if (r_state == S_WAIT_DATA) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end else begin
                r_lat_cnt <= '0;
            end
            if (w_capture) begin
                r_shift    <= fifo_dout;
                r_byte_cnt <= '0;
            end else if (w_advance) begin
                r_shift    <= w_shift_nxt;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    assign fifo_rd_en          = r_rd_en;
    assign tx_data             = r_tx_data;
    assign new_tx_data         = r_new_tx;
    assign f_FIFO_reading_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tdc_fifo_reader.sv
`default_nettype none
// Bench for tdc_fifo_reader: FIFO and UART models drive the DUT; a monitor logs
// strobes, pops and done pulses; expected byte streams are derived per word.
module tb_tdc_fifo_reader;
    localparam int DATA_BYTES = 3;
`ifdef SYNC_HEADER_EN
    localparam int FRAME_LEN = DATA_BYTES + 1;
`else
    localparam int FRAME_LEN = DATA_BYTES;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [23:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        f_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdc_fifo_reader #(.DATA_BYTES(DATA_BYTES), .READ_LATENCY(1), .MSB_FIRST(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fifo_empty          (fifo_empty),
        .fifo_dout           (fifo_dout),
        .fifo_rd_en          (fifo_rd_en),
        .tx_busy             (tx_busy),
        .tx_data             (tx_data),
        .new_tx_data         (new_tx_data),
        .f_FIFO_reading_done (f_done)
    );

    // FIFO model: one-cycle read latency
    logic [23:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Transmitter model: busy for a random number of cycles after each strobe
    logic uart_busy;
    int   busy_left;
    int   uart_n;
    int   busy_max = 0;
    logic force_busy = 1'b0;
    assign tx_busy = uart_busy | force_busy;
    always @(posedge clk) begin
        if (!rst_n) begin
            uart_busy <= 1'b0;
            busy_left <= 0;
        end else if (new_tx_data) begin
            uart_n = $urandom_range(busy_max, 0);
            uart_busy <= (uart_n != 0);
            busy_left <= uart_n;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            uart_busy <= 1'b0;
        end
    end

    // Monitor logs
    int         cyc = 0;
    logic [7:0] rx_byte [256];
    int         rx_cyc [256];
    int         rx_n = 0;
    int         done_cyc [64];
    int         done_after [64];
    int         done_n = 0;
    int         pop_cyc [64];
    int         pop_n = 0;
    int         bad_pop = 0;
    int         busy_viol = 0;
    int         space_viol = 0;
    int         last_strobe = -100;
    logic       busy_seen = 1'b0;

    always @(posedge clk) busy_seen = tx_busy;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (new_tx_data) begin
            rx_byte[rx_n] = tx_data;
            rx_cyc[rx_n]  = cyc;
            rx_n = rx_n + 1;
            if (busy_seen) busy_viol = busy_viol + 1;
            if (cyc - last_strobe < 2) space_viol = space_viol + 1;
            last_strobe = cyc;
        end
        if (f_done) begin
            done_cyc[done_n]   = cyc;
            done_after[done_n] = rx_n;
            done_n = done_n + 1;
        end
        if (fifo_rd_en) begin
            pop_cyc[pop_n] = cyc;
            pop_n = pop_n + 1;
            if (fifo_empty) bad_pop = bad_pop + 1;
        end
    end

    // Reference: expected byte stream and frame-end positions
    logic [7:0] exp_byte [256];
    int         exp_n = 0;
    int         exp_end [64];
    int         exp_fn = 0;
    int         chk_idx = 0;
    int         dchk_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [23:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
`ifdef SYNC_HEADER_EN
        exp_byte[exp_n] = 8'hA5;
        exp_n = exp_n + 1;
`endif
        for (int i = 0; i < DATA_BYTES; i++) begin
            exp_byte[exp_n] = 8'((w >> (8 * (DATA_BYTES - 1 - i))) & 24'hFF);
            exp_n = exp_n + 1;
        end
        exp_end[exp_fn] = exp_n;
        exp_fn = exp_fn + 1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_n < target && k < budget) begin step(); k++; end
        chk("done_timeout", 32'(done_n >= target), 32'd1);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int k = 0;
        while (rx_n < target && k < budget) begin step(); k++; end
        chk("byte_timeout", 32'(rx_n >= target), 32'd1);
    endtask

    task automatic check_frames();
        int a;
        for (int i = chk_idx; i < rx_n && i < exp_n; i++) chk("byte", 32'(rx_byte[i]), 32'(exp_byte[i]));
        chk("byte_count", rx_n, exp_n);
        chk_idx = rx_n;
        for (int j = dchk_idx; j < done_n; j++) begin
            chk("done_pos", done_after[j], exp_end[j]);
            a = (done_after[j] > 0) ? done_after[j] - 1 : 0;
            chk("done_timing", done_cyc[j], rx_cyc[a] + 1);
        end
        chk("frame_count", done_n, exp_fn);
        dchk_idx = done_n;
    endtask

    initial begin
        int base, dbase, pbase, rel, nw;
        // T1: reset held with FIFO non-empty
        rst_n = 1'b0;
        push_word(24'h123456);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("rst_new_tx", 32'(new_tx_data), 32'd0);
            chk("rst_done", 32'(f_done), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'h00);
        end
        chk("rst_pops", pop_n, 0);
        rst_n = 1'b1;

        // T2: single word, transmitter idle
        wait_done(1, 100);
        check_frames();
        chk("t2_pops", pop_n, 1);

        // T3: transmitter held busy after the first strobe
        busy_max = 0;
        base = rx_n;
        push_word(24'($urandom));
        wait_rx(base + 1, 100);
        force_busy = 1'b1;
        repeat (50) step();
        chk("t3_no_strobe", rx_n, base + 1);
        force_busy = 1'b0;
        rel = cyc;
        wait_rx(base + 2, 20);
        chk("t3_resume_cycle", rx_cyc[base + 1], rel + 1);
        wait_done(2, 100);
        check_frames();

        // T4: back-to-back words
        dbase = done_n;
        pbase = pop_n;
        push_word(24'hAABBCC);
        push_word(24'h010203);
        wait_done(dbase + 2, 200);
        check_frames();
        chk("t4_pops", pop_n, pbase + 2);
        chk("t4_b2b_pop", pop_cyc[pbase + 1], done_cyc[dbase] + 2);

        // T5: reset after the first strobe of a frame
        base = rx_n;
        dbase = done_n;
        pbase = pop_n;
        push_word(24'hDEADBE);
        wait_rx(base + 1, 100);
        rst_n = 1'b0;
        #1;
        chk("t5_new_tx", 32'(new_tx_data), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'h00);
        chk("t5_done", 32'(f_done), 32'd0);
        chk("t5_first_byte", 32'(rx_byte[base]), 32'(exp_byte[base]));
        exp_n = rx_n;
        exp_fn = exp_fn - 1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("t5_no_more_bytes", rx_n, base + 1);
        chk("t5_no_done", done_n, dbase);
        chk("t5_pops", pop_n, pbase + 1);
        check_frames();

        // Randomised words, gaps and transmitter busy times
        for (int r = 0; r < 6; r++) begin
            busy_max = $urandom_range(3, 0);
            nw = $urandom_range(3, 1);
            dbase = done_n;
            pbase = pop_n;
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(6, 0)) step();
                push_word(24'($urandom));
            end
            wait_done(dbase + nw, 300 * nw);
            check_frames();
            chk("rand_pops", pop_n, pbase + nw);
        end

        chk("frame_len", exp_end[0], FRAME_LEN);
        chk("pop_while_empty", bad_pop, 0);
        chk("strobe_while_busy", busy_viol, 0);
        chk("strobe_spacing", space_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
